fetch_unit: RTL and testbench

//   Instruction-fetch front end between the processor core and the synchronous imem.

---
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, addresses imem, handles stall and redirect.
// Optional perf counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
`ifdef FETCH_PERF_CNT_EN
    , parameter int CNT_W  = 32
`endif
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [DATA_W-1:0] q_imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1_out,
    output logic              instr_valid
`ifdef FETCH_PERF_CNT_EN
    , output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0]  bubble_count
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HOLD,
        ST_SQUASH
    } state_t;

    localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LP_ONE      = ADDR_W'(1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W-1:0]   r_pc_issue;
    logic [ADDR_W-1:0]   r_pc_inflight;
    logic                r_inflight_v;
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_pc_out;
    logic                r_valid;
    logic [DATA_W-1:0]   r_skid;
    logic [ADDR_W-1:0]   w_pc_issue_nx;
    logic [ADDR_W-1:0]   w_pc_inflight_nx;
    logic                w_inflight_v_nx;
    logic [DATA_W-1:0]   w_instr_nx;
    logic [ADDR_W-1:0]   w_pc_out_nx;
    logic                w_valid_nx;
    logic [DATA_W-1:0]   w_skid_nx;

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_BOOT;
        else       r_state <= w_state_nx;
    end

    // The imem re-reads pc_issue while held, so the word returned for
    // pc_inflight is parked in r_skid on the first stalled edge.
    always_comb begin
        w_state_nx       = r_state;
        w_pc_issue_nx    = r_pc_issue;
        w_pc_inflight_nx = r_pc_inflight;
        w_inflight_v_nx  = r_inflight_v;
        w_instr_nx       = r_instr;
        w_pc_out_nx      = r_pc_out;
        w_valid_nx       = r_valid;
        w_skid_nx        = r_skid;
        case (r_state)
            ST_BOOT: begin
                w_pc_inflight_nx = r_pc_issue;
                w_inflight_v_nx  = 1'b1;
                w_pc_issue_nx    = r_pc_issue + LP_ONE;
                w_state_nx       = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_issue_nx   = redirect_target;
                    w_inflight_v_nx = 1'b0;
                    w_valid_nx      = 1'b0;
                    w_state_nx      = ST_SQUASH;
                end else if (stall) begin
                    w_state_nx = ST_HOLD;
                    if (r_state == ST_RUN) w_skid_nx = q_imem;
                end else begin
                    w_instr_nx       = (r_state == ST_HOLD) ? r_skid : q_imem;
                    w_pc_out_nx      = r_pc_inflight;
                    w_valid_nx       = r_inflight_v;
                    w_pc_inflight_nx = r_pc_issue;
                    w_inflight_v_nx  = 1'b1;
                    w_pc_issue_nx    = r_pc_issue + LP_ONE;
                    w_state_nx       = ST_RUN;
                end
            end
            ST_SQUASH: begin
                w_valid_nx = 1'b0;
                if (redirect_valid) begin
                    w_pc_issue_nx   = redirect_target;
                    w_inflight_v_nx = 1'b0;
                end else if (!stall) begin
                    w_pc_inflight_nx = r_pc_issue;
                    w_inflight_v_nx  = 1'b1;
                    w_pc_issue_nx    = r_pc_issue + LP_ONE;
                    w_state_nx       = ST_RUN;
                end
            end
            default: w_state_nx = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc_issue    <= LP_RESET_PC;
            r_pc_inflight <= '0;
            r_inflight_v  <= 1'b0;
            r_instr       <= '0;
            r_pc_out      <= '0;
            r_valid       <= 1'b0;
            r_skid        <= '0;
        end else begin
            r_pc_issue    <= w_pc_issue_nx;
            r_pc_inflight <= w_pc_inflight_nx;
            r_inflight_v  <= w_inflight_v_nx;
            r_instr       <= w_instr_nx;
            r_pc_out      <= w_pc_out_nx;
            r_valid       <= w_valid_nx;
            r_skid        <= w_skid_nx;
        end
    end

    assign address_imem = r_pc_issue;
    assign instr_out    = r_instr;
    assign pc_out       = r_pc_out;
    assign pc_plus1_out = r_pc_out + LP_ONE;
    assign instr_valid  = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_fetch_inc;
    logic             w_bubble_inc;

    assign w_fetch_inc  = w_valid_nx && !stall;
    assign w_bubble_inc = !r_valid && (r_state != ST_BOOT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_fetch_inc && (r_fetch_cnt != '1))
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            if (w_bubble_inc && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign fetch_count  = r_fetch_cnt;
    assign bubble_count = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, wrap sequence, and
// randomized stall/redirect/reset traffic against a delivery-stream model.
module tb_fetch_unit;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;

    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] q1, q2;
    logic [DW-1:0] instr1, instr2;
    logic [AW-1:0] pc1, pc2, pp1, pp2;
    logic          v1, v2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   fc1, bc1, fc2, bc2;
`endif

    logic [DW-1:0] mem [0:4095];

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut1 (
        .clock(clock), .reset(reset), .address_imem(addr1), .q_imem(q1),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .instr_out(instr1), .pc_out(pc1),
        .pc_plus1_out(pp1), .instr_valid(v1)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fc1), .bubble_count(bc1)
`endif
    );

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'hFFE)) dut2 (
        .clock(clock), .reset(reset), .address_imem(addr2), .q_imem(q2),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .instr_out(instr2), .pc_out(pc2),
        .pc_plus1_out(pp2), .instr_valid(v2)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fc2), .bubble_count(bc2)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        q1 <= mem[addr1];
        q2 <= mem[addr2];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: a stream of delivered addresses; gap counts edges left
    // before the next address appears after reset or a redirect.
    logic          m_boot = 1'b0;
    int            m_gap = 0;
    logic [AW-1:0] m_seq = '0;
    logic          m_valid = 1'b0;
    logic [AW-1:0] m_pc = '0;
    logic [DW-1:0] m_instr = '0;

    function automatic void model_step();
        if (reset) begin
            m_boot  = 1'b1;
            m_gap   = 2;
            m_seq   = '0;
            m_valid = 1'b0;
            m_pc    = '0;
            m_instr = '0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_gap  = 1;
        end else if (redirect_valid) begin
            m_seq   = redirect_target;
            m_gap   = 2;
            m_valid = 1'b0;
        end else if (stall) begin
            m_gap = m_gap;
        end else if (m_gap > 1) begin
            m_gap = m_gap - 1;
        end else begin
            m_gap   = 0;
            m_valid = 1'b1;
            m_pc    = m_seq;
            m_instr = mem[m_seq];
            m_seq   = m_seq + 12'd1;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic drive(input logic r, input logic s, input logic d,
                         input logic [AW-1:0] t);
        reset           = r;
        stall           = s;
        redirect_valid  = d;
        redirect_target = t;
    endtask

    typedef struct {
        logic          rst;
        logic          stl;
        logic          rdr;
        logic [AW-1:0] tgt;
        logic          ev;
        logic [AW-1:0] epc;
        logic [DW-1:0] ein;
        logic [AW-1:0] ead;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic s, input logic d,
                       input logic [AW-1:0] t, input logic ev,
                       input logic [AW-1:0] epc, input logic [DW-1:0] ein,
                       input logic [AW-1:0] ead);
        vec_t v;
        v.rst = r; v.stl = s; v.rdr = d; v.tgt = t;
        v.ev = ev; v.epc = epc; v.ein = ein; v.ead = ead;
        tv.push_back(v);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 12'h0);
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i) + 32'h100;

        add(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 32'h000, 12'h000);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 32'h000, 12'h001);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 32'h100, 12'h002);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h001, 32'h101, 12'h003);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 32'h102, 12'h004);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 32'h103, 12'h005);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 32'h104, 12'h006);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h005, 32'h105, 12'h007);
        add(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 32'h105, 12'h007);
        add(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 32'h105, 12'h007);
        add(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 32'h105, 12'h007);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h006, 32'h106, 12'h008);
        add(1'b0, 1'b0, 1'b1, 12'h040, 1'b0, 12'h006, 32'h106, 12'h040);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h006, 32'h106, 12'h041);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h040, 32'h140, 12'h042);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h041, 32'h141, 12'h043);
        add(1'b0, 1'b1, 1'b1, 12'h080, 1'b0, 12'h041, 32'h141, 12'h080);
        add(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h041, 32'h141, 12'h080);
        add(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h041, 32'h141, 12'h080);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h041, 32'h141, 12'h081);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h080, 32'h180, 12'h082);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h081, 32'h181, 12'h083);
        add(1'b0, 1'b0, 1'b1, 12'h010, 1'b0, 12'h081, 32'h181, 12'h010);
        add(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 32'h000, 12'h000);
        add(1'b0, 1'b1, 1'b1, 12'h300, 1'b0, 12'h000, 32'h000, 12'h001);
        add(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 32'h100, 12'h002);

        @(negedge clock);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].stl, tv[i].rdr, tv[i].tgt);
            tick();
            check($sformatf("row%0d valid", i), 32'(v1), 32'(tv[i].ev));
            check($sformatf("row%0d pc", i), 32'(pc1), 32'(tv[i].epc));
            check($sformatf("row%0d instr", i), instr1, tv[i].ein);
            check($sformatf("row%0d addr", i), 32'(addr1), 32'(tv[i].ead));
            check($sformatf("row%0d pc+1", i), 32'(pp1),
                  32'(tv[i].epc + 12'd1));
        end

        // PC wrap on the RESET_PC=0xFFE instance
        drive(1'b1, 1'b0, 1'b0, 12'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 12'h0);
        tick();
        check("wrap boot valid", 32'(v2), 32'd0);
        tick();
        check("wrap pc0", 32'(pc2), 32'hFFE);
        check("wrap instr0", instr2, 32'h10FE);
        check("wrap valid0", 32'(v2), 32'd1);
        tick();
        check("wrap pc1", 32'(pc2), 32'hFFF);
        check("wrap instr1", instr2, 32'h10FF);
        check("wrap pc+1 at FFF", 32'(pp2), 32'h000);
        tick();
        check("wrap pc2", 32'(pc2), 32'h000);
        check("wrap instr2", instr2, 32'h100);

        // Randomized traffic against the model
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        drive(1'b1, 1'b0, 1'b0, 12'h0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, AW'($urandom));
            tick();
            check($sformatf("rand%0d valid", c), 32'(v1), 32'(m_valid));
            check($sformatf("rand%0d pc", c), 32'(pc1), 32'(m_pc));
            check($sformatf("rand%0d instr", c), instr1, m_instr);
            check($sformatf("rand%0d pc+1", c), 32'(pp1),
                  32'(m_pc + 12'd1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
